// File: rtl/led_display_package.sv
// rtl/led_display_package.sv - shared LED display types and constants
package led_display_package;

    localparam int GL_NUM_COLS  = 64;
    localparam int GL_NUM_ROWS  = 32;
    localparam int GL_NUM_LANES = 1;
    localparam int GL_ADDR_W    = $clog2(GL_NUM_ROWS / 2);
    localparam int GL_BITS_W    = $clog2(GL_NUM_COLS + 2);
    localparam int GL_OE_CNT_W  = 16;

    typedef struct packed {
        logic [GL_NUM_COLS-1:0] top_r;
        logic [GL_NUM_COLS-1:0] top_g;
        logic [GL_NUM_COLS-1:0] top_b;
        logic [GL_NUM_COLS-1:0] bot_r;
        logic [GL_NUM_COLS-1:0] bot_g;
        logic [GL_NUM_COLS-1:0] bot_b;
    } rgb_row_t;

    typedef struct packed {
        rgb_row_t [GL_NUM_LANES-1:0] data;
        logic [GL_ADDR_W-1:0]        addr;
        logic [GL_BITS_W-1:0]        bits;
        logic                        err;
        logic [GL_OE_CNT_W-1:0]      oe_cycles;
    } hub75_row_entry_t;

    localparam int GL_ROW_ENTRY_W = $bits(hub75_row_entry_t);

    // Flat width of a row entry for non-default geometries; same field order as hub75_row_entry_t.
    function automatic int row_entry_w(input int cols, input int lanes, input int addr_w, input int oe_w);
        return 6 * cols * lanes + addr_w + $clog2(cols + 2) + 1 + oe_w;
    endfunction

endpackage

// File: rtl/row_fifo.sv
// rtl/row_fifo.sv - generic synchronous first-word-fall-through FIFO
module row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hub75_row_monitor.sv
// rtl/hub75_row_monitor.sv - HUB75 row receiver: oversampled shift capture, per-row checks, FIFO output
module hub75_row_monitor
    import led_display_package::*;
#(
    parameter int NUM_COLS   = GL_NUM_COLS,
    parameter int NUM_ROWS   = GL_NUM_ROWS,
    parameter int NUM_LANES  = GL_NUM_LANES,
    parameter int FIFO_DEPTH = 4,
    parameter int OE_CNT_W   = GL_OE_CNT_W,
    parameter int ADDR_W     = $clog2(NUM_ROWS / 2),
    parameter int BITS_W     = $clog2(NUM_COLS + 2)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bclk,
    input  logic [3*NUM_LANES-1:0]        rgb_top,
    input  logic [3*NUM_LANES-1:0]        rgb_bot,
    input  logic [ADDR_W-1:0]             addr_in,
    input  logic                          oe_in,
    input  logic                          le_in,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [6*NUM_COLS*NUM_LANES-1:0] row_data,
    output logic [ADDR_W-1:0]             row_addr,
    output logic [BITS_W-1:0]             row_bits,
    output logic                          row_err,
    output logic [OE_CNT_W-1:0]           row_oe_cycles,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);
    localparam int NCH     = 6 * NUM_LANES;
    localparam int DATA_W  = NCH * NUM_COLS;
    localparam int ENTRY_W = row_entry_w(NUM_COLS, NUM_LANES, ADDR_W, OE_CNT_W);
    localparam logic [BITS_W-1:0] BITS_MAX = BITS_W'(NUM_COLS + 1);

    logic [1:0]                      bclk_s, le_s, oe_s;
    logic                            bclk_prev, le_prev;
    logic [1:0][3*NUM_LANES-1:0]     top_d, bot_d;
    logic [1:0][ADDR_W-1:0]          addr_d;
    logic [1:0]                      arm_cnt;

    logic [NCH-1:0][NUM_COLS-1:0]    sh, sh_next;
    logic [NCH-1:0]                  in_bit;
    logic [DATA_W-1:0]               row_d;
    logic [BITS_W-1:0]               bit_cnt, bit_cnt_next;
    logic [OE_CNT_W-1:0]             oe_cnt, oe_cnt_next;

    logic                            armed, bclk_rise, le_rise;
    logic                            pop, drop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]              push_entry, head;

    always_comb begin
        armed        = (arm_cnt == 2'd3);
        bclk_rise    = armed && bclk_s[1] && !bclk_prev;
        le_rise      = armed && le_s[1] && !le_prev;
        in_bit       = '0;
        sh_next      = sh;
        bit_cnt_next = bit_cnt;
        oe_cnt_next  = oe_cnt;
        row_d        = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int c = 0; c < 3; c++) begin
                in_bit[l*6 + c]     = top_d[1][3*l + c];
                in_bit[l*6 + 3 + c] = bot_d[1][3*l + c];
            end
        end
        if (bclk_rise) begin
            for (int k = 0; k < NCH; k++) begin
                sh_next[k] = {sh[k][NUM_COLS-2:0], in_bit[k]};
            end
            if (bit_cnt != BITS_MAX) begin
                bit_cnt_next = bit_cnt + BITS_W'(1);
            end
        end
        if (!oe_s[1] && oe_cnt != '1) begin
            oe_cnt_next = oe_cnt + OE_CNT_W'(1);
        end
        // Lane block order is top.r first (MSBs) down to bot.b; lane 0 sits in the LSBs.
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int c = 0; c < 6; c++) begin
                row_d[l*6*NUM_COLS + (5 - c)*NUM_COLS +: NUM_COLS] = sh_next[l*6 + c];
            end
        end
    end

    assign push_entry = {row_d, addr_d[1], bit_cnt_next,
                         (bit_cnt_next != BITS_W'(NUM_COLS)), oe_cnt_next};
    assign row_valid  = !fifo_empty;
    assign pop        = row_valid && row_ready;
    assign drop       = le_rise && fifo_full && !pop;
    assign {row_data, row_addr, row_bits, row_err, row_oe_cycles} = head;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s    <= '0;
            le_s      <= '0;
            oe_s      <= '1;
            bclk_prev <= 1'b0;
            le_prev   <= 1'b0;
            top_d     <= '0;
            bot_d     <= '0;
            addr_d    <= '0;
            arm_cnt   <= '0;
            sh        <= '0;
            bit_cnt   <= '0;
            oe_cnt    <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            bclk_s    <= {bclk_s[0], bclk};
            le_s      <= {le_s[0], le_in};
            oe_s      <= {oe_s[0], oe_in};
            bclk_prev <= bclk_s[1];
            le_prev   <= le_s[1];
            top_d     <= {top_d[0], rgb_top};
            bot_d     <= {bot_d[0], rgb_bot};
            addr_d    <= {addr_d[0], addr_in};
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            sh      <= sh_next;
            bit_cnt <= le_rise ? '0 : bit_cnt_next;
            oe_cnt  <= le_rise ? '0 : oe_cnt_next;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (le_rise),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
